// File: rtl/store_buffer.sv
// Speculative in-order store buffer: LSU stores wait for ROB commit, then drain to the D-cache.
// Define STORE_BUFFER_FWD_EN for byte-accurate load forwarding; otherwise word-address hits stall.
module store_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 32,
    parameter int MICROOP    = 5,
    parameter int ROB_TICKET = 3,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_valid,
    input  logic [ADDR_BITS-1:0]  push_address,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic [MICROOP-1:0]    push_microop,
    input  logic [ROB_TICKET-1:0] push_ticket,
    output logic                  full,
    output logic                  empty,
    input  logic                  commit_valid,
    input  logic [ROB_TICKET-1:0] commit_ticket,
    input  logic                  flush,
    input  logic [ADDR_BITS-1:0]  frw_address,
    input  logic [MICROOP-1:0]    frw_microop,
    output logic [DATA_WIDTH-1:0] frw_data,
    output logic                  frw_valid,
    output logic                  frw_stall,
    output logic                  cache_wb_valid,
    output logic [ADDR_BITS-1:0]  cache_wb_address,
    output logic [DATA_WIDTH-1:0] cache_wb_data,
    output logic [MICROOP-1:0]    cache_wb_microop,
    input  logic                  cache_wb_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [MICROOP-1:0] OP_LW  = MICROOP'(1);
    localparam logic [MICROOP-1:0] OP_LH  = MICROOP'(2);
    localparam logic [MICROOP-1:0] OP_LHU = MICROOP'(3);
    localparam logic [MICROOP-1:0] OP_LB  = MICROOP'(4);
    localparam logic [MICROOP-1:0] OP_LBU = MICROOP'(5);
    localparam logic [MICROOP-1:0] OP_SW  = MICROOP'(6);
    localparam logic [MICROOP-1:0] OP_SH  = MICROOP'(7);
    localparam logic [MICROOP-1:0] OP_SB  = MICROOP'(8);

    logic [PW-1:0] head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d, ncmt_q, ncmt_d;

    logic [ADDR_BITS-1:0]  addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [MICROOP-1:0]    uop_q  [DEPTH];
    logic [ROB_TICKET-1:0] tkt_q  [DEPTH];
    logic [3:0]            mask_q [DEPTH];

    logic push_fire, commit_fire, drain_fire;

    function automatic logic [3:0] byte_mask(input logic [MICROOP-1:0] uop, input logic [1:0] off);
        logic [3:0] sz;
        logic [7:0] sh;
        case (uop)
            OP_SW, OP_LW:         sz = 4'b1111;
            OP_SH, OP_LH, OP_LHU: sz = 4'b0011;
            OP_SB, OP_LB, OP_LBU: sz = 4'b0001;
            default:              sz = 4'b0000;
        endcase
        sh = {4'b0000, sz} << off;
        return sh[3:0];
    endfunction

    assign full           = (count_q == CW'(DEPTH));
    assign empty          = (count_q == '0);
    assign cache_wb_valid = (ncmt_q != '0);
    assign commit_fire    = commit_valid && (count_q > ncmt_q);
    assign drain_fire     = cache_wb_valid && cache_wb_ready;
    assign push_fire      = push_valid && !full && !flush;

    assign cache_wb_address = addr_q[head_q];
    assign cache_wb_data    = data_q[head_q];
    assign cache_wb_microop = uop_q[head_q];

    // Same-edge ordering: commit, then drain, then flush (rewinds to committed state), then push.
    always_comb begin
        head_d  = head_q + PW'(drain_fire);
        cmt_d   = cmt_q + PW'(commit_fire);
        ncmt_d  = ncmt_q + CW'(commit_fire) - CW'(drain_fire);
        count_d = count_q - CW'(drain_fire);
        tail_d  = tail_q;
        if (flush) begin
            tail_d  = cmt_d;
            count_d = ncmt_d;
        end else if (push_fire) begin
            tail_d  = tail_q + PW'(1);
            count_d = count_d + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            cmt_q   <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ncmt_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                uop_q[i]  <= '0;
                tkt_q[i]  <= '0;
                mask_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            cmt_q   <= cmt_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ncmt_q  <= ncmt_d;
            if (push_fire) begin
                addr_q[tail_q] <= push_address;
                data_q[tail_q] <= push_data;
                uop_q[tail_q]  <= push_microop;
                tkt_q[tail_q]  <= push_ticket;
                mask_q[tail_q] <= byte_mask(push_microop, push_address[1:0]);
            end
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    logic [3:0]            ld_mask, sz_mask;
    logic [PW-1:0]         idx, sel;
    logic                  found;
    logic [1:0]            shift;
    logic [DATA_WIDTH-1:0] lane_bits;

    // Walk youngest to oldest; the first byte-overlapping entry decides hit or stall.
    always_comb begin
        ld_mask   = byte_mask(frw_microop, frw_address[1:0]);
        sz_mask   = byte_mask(frw_microop, 2'b00);
        idx       = '0;
        sel       = '0;
        found     = 1'b0;
        shift     = '0;
        lane_bits = '0;
        frw_valid = 1'b0;
        frw_stall = 1'b0;
        frw_data  = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = tail_q - PW'(k + 1);
            if (!found && (CW'(k) < count_q)
                && (addr_q[idx][ADDR_BITS-1:2] == frw_address[ADDR_BITS-1:2])
                && ((mask_q[idx] & ld_mask) != 4'b0000)) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        for (int unsigned l = 0; l < 4; l++) begin
            lane_bits[8*l +: 8] = {8{sz_mask[l]}};
        end
        shift = frw_address[1:0] - addr_q[sel][1:0];
        if (found) begin
            if ((mask_q[sel] & ld_mask) == ld_mask) begin
                frw_valid = 1'b1;
                frw_data  = (data_q[sel] >> {shift, 3'b000}) & lane_bits;
            end else begin
                frw_stall = 1'b1;
            end
        end
    end

    logic unused_sink;
    assign unused_sink = ^{commit_ticket, tkt_q[cmt_q]};
`else
    logic [PW-1:0] idx;

    always_comb begin
        idx       = '0;
        frw_valid = 1'b0;
        frw_data  = '0;
        frw_stall = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if ((CW'(k) < count_q)
                && (addr_q[idx][ADDR_BITS-1:2] == frw_address[ADDR_BITS-1:2])) begin
                frw_stall = 1'b1;
            end
        end
    end

    logic unused_sink;
    assign unused_sink = ^{commit_ticket, tkt_q[cmt_q], frw_microop, frw_address[1:0], mask_q[head_q]};
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: forwarding vector table plus a queue scoreboard for drains.
module tb_store_buffer;
    localparam int DW = 32, AW = 32, UW = 5, TW = 3, DEPTH = 4;

    localparam logic [UW-1:0] LW = 5'b00001, LH = 5'b00010, LHU = 5'b00011, LB = 5'b00100, LBU = 5'b00101;
    localparam logic [UW-1:0] SW = 5'b00110, SH = 5'b00111, SB = 5'b01000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          push_valid = 1'b0;
    logic [AW-1:0] push_address = '0;
    logic [DW-1:0] push_data = '0;
    logic [UW-1:0] push_microop = '0;
    logic [TW-1:0] push_ticket = '0;
    logic          full, empty;
    logic          commit_valid = 1'b0;
    logic [TW-1:0] commit_ticket = '0;
    logic          flush = 1'b0;
    logic [AW-1:0] frw_address = '0;
    logic [UW-1:0] frw_microop = '0;
    logic [DW-1:0] frw_data;
    logic          frw_valid, frw_stall;
    logic          cache_wb_valid;
    logic [AW-1:0] cache_wb_address;
    logic [DW-1:0] cache_wb_data;
    logic [UW-1:0] cache_wb_microop;
    logic          cache_wb_ready = 1'b0;

    always #5 clk = ~clk;

    store_buffer #(.DATA_WIDTH(DW), .ADDR_BITS(AW), .MICROOP(UW), .ROB_TICKET(TW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .push_valid(push_valid), .push_address(push_address), .push_data(push_data),
        .push_microop(push_microop), .push_ticket(push_ticket),
        .full(full), .empty(empty),
        .commit_valid(commit_valid), .commit_ticket(commit_ticket), .flush(flush),
        .frw_address(frw_address), .frw_microop(frw_microop),
        .frw_data(frw_data), .frw_valid(frw_valid), .frw_stall(frw_stall),
        .cache_wb_valid(cache_wb_valid), .cache_wb_address(cache_wb_address),
        .cache_wb_data(cache_wb_data), .cache_wb_microop(cache_wb_microop),
        .cache_wb_ready(cache_wb_ready)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [UW-1:0] u;
    } st_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [UW-1:0] u;
        logic          fv;
        logic          fs;
        logic [DW-1:0] fd;
        logic          ws;
    } vec_t;

    st_t sb_q[$];
    int  m_ncmt = 0;
    int  drained = 0;
    int  total = 0;
    int  bad = 0;
    int  tick = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // One clock: drive inputs, compare against the queue model, then advance the model.
    task automatic cycle(input logic pv, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                         input logic [UW-1:0] pu, input logic cv, input logic fl, input logic rdy);
        int   pre_size, pre_ncmt;
        logic c_ok, d_ok;
        st_t  e;
        @(negedge clk);
        push_valid = pv; push_address = pa; push_data = pd; push_microop = pu;
        push_ticket = TW'(tick); commit_valid = cv; commit_ticket = TW'(tick);
        flush = fl; cache_wb_ready = rdy;
        tick++;
        #1;
        pre_size = sb_q.size();
        pre_ncmt = m_ncmt;
        check("full", full, 64'(pre_size == DEPTH));
        check("empty", empty, 64'(pre_size == 0));
        check("wb_valid", cache_wb_valid, 64'(pre_ncmt > 0));
        c_ok = cv && (pre_size > pre_ncmt);
        d_ok = rdy && (pre_ncmt > 0);
        if (d_ok) begin
            e = sb_q.pop_front();
            check("wb_address", cache_wb_address, e.a);
            check("wb_data", cache_wb_data, e.d);
            check("wb_microop", cache_wb_microop, e.u);
            drained++;
        end
        m_ncmt = pre_ncmt + int'(c_ok) - int'(d_ok);
        if (fl) begin
            while (sb_q.size() > m_ncmt) sb_q.delete(sb_q.size() - 1);
        end else if (pv && pre_size < DEPTH) begin
            sb_q.push_back('{pa, pd, pu});
        end
        @(posedge clk);
        #1;
        push_valid = 1'b0; commit_valid = 1'b0; flush = 1'b0; cache_wb_ready = 1'b0;
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, rdy);
    endtask

    task automatic fwd(input string nm, input logic [AW-1:0] a, input logic [UW-1:0] u,
                       input logic fv, input logic fs, input logic [DW-1:0] fd, input logic ws);
        @(negedge clk);
        frw_address = a; frw_microop = u;
        #1;
`ifdef STORE_BUFFER_FWD_EN
        check({nm, " frw_valid"}, frw_valid, fv);
        check({nm, " frw_stall"}, frw_stall, fs);
        check({nm, " frw_data"}, frw_data, fd);
`else
        check({nm, " frw_valid"}, frw_valid, 0);
        check({nm, " frw_stall"}, frw_stall, ws);
        check({nm, " frw_data"}, frw_data, 0);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        sb_q.delete();
        m_ncmt = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[15];
        tbl[0]  = '{32'h102, LBU, 1'b1, 1'b0, 32'h000000AD, 1'b1};
        tbl[1]  = '{32'h100, LW,  1'b1, 1'b0, 32'hDEADBEEF, 1'b1};
        tbl[2]  = '{32'h100, LH,  1'b1, 1'b0, 32'h0000BEEF, 1'b1};
        tbl[3]  = '{32'h102, LHU, 1'b1, 1'b0, 32'h0000DEAD, 1'b1};
        tbl[4]  = '{32'h103, LB,  1'b1, 1'b0, 32'h000000DE, 1'b1};
        tbl[5]  = '{32'h204, LW,  1'b0, 1'b1, 32'h00000000, 1'b1};
        tbl[6]  = '{32'h205, LBU, 1'b1, 1'b0, 32'h00000055, 1'b1};
        tbl[7]  = '{32'h204, LB,  1'b0, 1'b0, 32'h00000000, 1'b1};
        tbl[8]  = '{32'h300, LH,  1'b1, 1'b0, 32'h00002222, 1'b1};
        tbl[9]  = '{32'h302, LB,  1'b1, 1'b0, 32'h00000011, 1'b1};
        tbl[10] = '{32'h300, LW,  1'b0, 1'b1, 32'h00000000, 1'b1};
        tbl[11] = '{32'h301, LBU, 1'b1, 1'b0, 32'h00000022, 1'b1};
        tbl[12] = '{32'h400, LW,  1'b0, 1'b0, 32'h00000000, 1'b0};
        tbl[13] = '{32'h206, LH,  1'b0, 1'b0, 32'h00000000, 1'b1};
        tbl[14] = '{32'h600, LW,  1'b0, 1'b0, 32'h00000000, 1'b0};

        #2 rst_n = 1'b0;
        #1;
        check("rst full", full, 0);
        check("rst empty", empty, 1);
        check("rst wb_valid", cache_wb_valid, 0);
        check("rst frw_valid", frw_valid, 0);
        check("rst frw_stall", frw_stall, 0);
        check("rst frw_data", frw_data, 0);
        check("rst wb_address", cache_wb_address, 0);
        check("rst wb_data", cache_wb_data, 0);
        check("rst wb_microop", cache_wb_microop, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to full; the fifth push must be dropped.
        cycle(1'b1, 32'h100, 32'hDEADBEEF, SW, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h205, 32'h00000055, SB, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h300, 32'h11111111, SW, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h300, 32'h00002222, SH, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h600, 32'h66666666, SW, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 15; i++) begin
            fwd($sformatf("fwd%0d", i), tbl[i].a, tbl[i].u, tbl[i].fv, tbl[i].fs, tbl[i].fd, tbl[i].ws);
        end

        // Commit two with the cache ready: writes leave in order.
        cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        check("drained after commit2", drained, 2);

        // Flush in the same cycle as a commit and a push.
        do_reset();
        drained = 0;
        cycle(1'b1, 32'h700, 32'hA0A0A0A0, SW, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h710, 32'h000000BB, SB, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h722, 32'h0000CCCC, SH, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h730, 32'hD0D0D0D0, SW, 1'b1, 1'b1, 1'b0);
        fwd("flushed C", 32'h720, LW, 1'b0, 1'b0, 32'h0, 1'b0);
        fwd("flushed D", 32'h730, LW, 1'b0, 1'b0, 32'h0, 1'b0);
        fwd("kept B", 32'h710, LBU, 1'b1, 1'b0, 32'h000000BB, 1'b1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        check("drained after flush", drained, 2);

        // A pushed store becomes visible to lookups one cycle later.
        frw_address = 32'h500; frw_microop = LW;
        @(negedge clk);
        push_valid = 1'b1; push_address = 32'h500; push_data = 32'hCAFEF00D; push_microop = SW;
        #1;
        check("lat same-cycle frw_valid", frw_valid, 0);
        check("lat same-cycle frw_stall", frw_stall, 0);
        sb_q.push_back('{32'h500, 32'hCAFEF00D, SW});
        @(posedge clk);
        #1 push_valid = 1'b0;
        fwd("lat next-cycle", 32'h500, LW, 1'b1, 1'b0, 32'hCAFEF00D, 1'b1);

        // Asynchronous reset while a committed store waits on the cache.
        cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("pre-reset wb_valid", cache_wb_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async rst wb_valid", cache_wb_valid, 0);
        check("async rst empty", empty, 1);
        check("async rst full", full, 0);
        check("async rst wb_address", cache_wb_address, 0);
        sb_q.delete();
        m_ncmt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
# store_buffer

Speculative store buffer between the load/store unit and the data cache. It accepts executed stores from the LSU store interface and holds them in program order until the ROB commits them. Committed stores drain to the data cache write port. Younger loads get combinational store-to-load forwarding (or a stall) on the LSU forward interface.

## Interface

Parameters:
- DATA_WIDTH, 32, data bits (byte lanes = DATA_WIDTH/8 = 4)
- ADDR_BITS, 32, address bits
- MICROOP, 5, microoperation bits
- ROB_TICKET, 3, ROB ticket bits
- DEPTH, 4, entries (power of two, ≥2)

Ports:
- clk  in  1  clock, single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- push_valid  in  1  LSU store valid
- push_address  in  ADDR_BITS  store address
- push_data  in  DATA_WIDTH  store data, right-aligned
- push_microop  in  MICROOP  00110 SW, 00111 SH, 01000 SB
- push_ticket  in  ROB_TICKET  store ROB ticket
- full  out  1  no free entry
- empty  out  1  no valid entry
- commit_valid  in  1  ROB commits the oldest uncommitted store
- commit_ticket  in  ROB_TICKET  ticket of the committing store
- flush  in  1  misprediction; discard all uncommitted entries
- frw_address  in  ADDR_BITS  load address
- frw_microop  in  MICROOP  00001 LW, 00010 LH, 00011 LHU, 00100 LB, 00101 LBU
- frw_data  out  DATA_WIDTH  forwarded load bytes, right-aligned, upper bits zero
- frw_valid  out  1  full forward hit
- frw_stall  out  1  partial overlap; load must wait
- cache_wb_valid  out  1  committed head store ready for the cache
- cache_wb_address / cache_wb_data / cache_wb_microop  out  ADDR_BITS / DATA_WIDTH / MICROOP  head entry fields
- cache_wb_ready  in  1  cache accepts the write

## Operation

- Storage is a circular FIFO with three pointers, each log2(DEPTH) bits wide and wrapping modulo DEPTH:
  - head: oldest entry
  - cmt: oldest uncommitted entry
  - tail: next free entry
- Counters: count (0..DEPTH) and ncmt (committed entries).
- Each entry holds address, data, microop, ticket and a byte mask.
- Byte mask = size mask (W=1111, H=0011, B=0001) shifted left by address[1:0], clipped to 4 bits.
- Push: if push_valid & ~full & ~flush, write the entry at tail, then tail++ and count++. A push while full is dropped.
- Commit: commit_valid and count>ncmt marks the entry at cmt as committed, then cmt++ and ncmt++. Commit with no uncommitted entry is ignored.
- Drain:
  - cache_wb_valid = (ncmt>0). The outputs reflect the head entry.
  - On cache_wb_valid & cache_wb_ready: head++, count--, ncmt--.
- Flush: tail := cmt (after any same-cycle commit) and count := ncmt (after any same-cycle drain). A push in the same cycle is discarded.
- Forward lookup is combinational over uncommitted and committed entries alike:
  - Compute the load mask the same way as the store mask.
  - An entry overlaps the load when address[ADDR_BITS-1:2] are equal and the byte masks AND to a nonzero value.
  - Search from youngest to oldest; the first overlapping entry is selected.
  - If the selected mask covers the whole load mask: frw_valid=1, frw_data = selected data shifted by (load addr[1:0] − store addr[1:0]) bytes, then masked to the load size.
  - Otherwise: frw_stall=1 and frw_valid=0.
  - No overlap: both outputs 0, frw_data=0.
- A store pushed this cycle is not visible to the lookup until the next cycle.

## Timing

- Reset: all pointers and counters are 0. Outputs reset to full=0, empty=1, cache_wb_valid=0, frw_valid=0, frw_stall=0, frw_data=0, and cache_wb_* = 0.
- full and empty are decoded from registered count only. A push is rejected while full, even if a drain happens in the same cycle.
- Latencies:
  - push → forwardable: 1 cycle
  - commit → cache_wb_valid: 1 cycle
  - cache_wb_ready handshake pops the entry at the same clock edge
- Several events in one cycle (push, commit, drain, flush) all apply at the same clock edge, in the order: commit, drain, flush, push.
- Reset asserted mid-operation clears the buffer immediately, without waiting for a clock edge; all entries are discarded.

## Configuration

- STORE_BUFFER_FWD_EN defined: full forwarding as described above.
- Not defined:
  - frw_valid=0 and frw_data=0 at all times.
  - frw_stall=1 whenever any valid entry matches address[ADDR_BITS-1:2], irrespective of the byte masks.
  - The shift/select datapath is removed.

## Test plan

- Forward hit: push SW 0x100 data 0xDEADBEEF, next cycle LBU 0x102 → frw_valid=1, frw_data=0x000000AD, frw_stall=0.
- Partial overlap: push SB 0x101 data 0x55, then LW 0x100 → frw_stall=1, frw_valid=0.
- Youngest wins: push SW 0x200 0x11111111, then SH 0x200 0x2222, then LH 0x200 → frw_data=0x00002222.
- Fill and drain: push 4 stores → full=1, a 5th push is dropped. Commit 2 with cache_wb_ready=1 → two writes in order, ending with count=2, full=0.
- Flush: 3 stores, commit 1, flush in the same cycle as a commit and a push → count=2, tail=cmt, the pushed store is absent, and only the 2 committed stores drain.
- Reset mid-drain: with cache_wb_valid=1, pull rst_n low between clock edges → cache_wb_valid=0 and empty=1 immediately.
